// File: rtl/udp_pkg.sv
// Shared constants and state encoding for the GMII UDP/IPv4 receive and transmit paths.
package udp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_ETH_HEAD,
        ST_IP_HEAD,
        ST_UDP_HEAD,
        ST_RX_DATA,
        ST_DISCARD
    } rx_state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam int          ETH_HEAD_LEN  = 14;
    localparam int          IP_HEAD_BYTES = 20;
    localparam int          UDP_HEAD_LEN  = 8;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // Byte idx of a 48-bit address in wire order (idx 0 = most significant byte).
    function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [2:0] idx);
        logic [47:0] s;
        s = v << (8 * idx);
        return s[47:40];
    endfunction

endpackage

// File: rtl/udp_rx_csum.sv
// Ones-complement halfword accumulator with end-around-carry fold; shared by RX and TX checksum paths.
module udp_rx_csum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add_en,
    input  logic [15:0] add_hw,
    input  logic        fold_en,
    output logic [15:0] sum
);

    logic [19:0] acc;

    // 20 bits hold ten halfwords without overflow; two folds then yield the 16-bit result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + {4'd0, add_hw};
        end else if (fold_en) begin
            acc <= {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
        end
    end

    assign sum = acc[15:0];

endmodule

// File: rtl/udp_recv.sv
// GMII UDP/IPv4 receiver: strips preamble and headers, filters on MAC/IP/protocol, emits 32-bit payload words.
// Define UDP_RECV_IP_CHECKSUM_EN to reject frames whose IPv4 header checksum does not verify.
module udp_recv
    import udp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC_ADDR = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP_ADDR  = {8'd192, 8'd168, 8'd1, 8'd123},
    parameter logic [3:0]  IP_VERSION     = 4'd4,
    parameter logic [3:0]  IP_HEAD_LEN    = 4'd5,
    parameter logic [7:0]  PROTOCOL       = 8'd17
) (
    input  logic        eth_rxc,
    input  logic        rst,
    input  logic [7:0]  eth_rxd,
    input  logic        eth_rxdv,
    output logic [31:0] rx_data,
    output logic        rx_data_en,
    output logic [15:0] rx_byte_num,
    output logic        rx_pkg_done,
    output logic        rx_err,
    output logic [47:0] src_mac_addr,
    output logic [31:0] src_ip_addr,
    output logic [15:0] src_udp_port
);

    rx_state_t   state, next_state;
    logic [10:0] cnt;

    logic        mac_uni_ok, mac_bc_ok, uni_now, bc_now;
    logic [47:0] src_mac_sh;
    logic [31:0] src_ip_sh;
    logic [15:0] src_port_sh;
    logic [15:0] udp_len, udp_len_now;
    logic [31:0] word_sh, word_nxt;
    logic        last_byte;
    logic        err_nxt, done_nxt, strobe_nxt, hdr_take;

    function automatic logic [7:0] ip_byte(input logic [1:0] idx);
        logic [31:0] s;
        s = BOARD_IP_ADDR << (8 * idx);
        return s[31:24];
    endfunction

`ifdef UDP_RECV_IP_CHECKSUM_EN
    logic [7:0]  hw_hi;
    logic [15:0] csum_sum;

    udp_rx_csum u_csum (
        .clk     (eth_rxc),
        .rst     (rst),
        .clr     (state == ST_ETH_HEAD),
        .add_en  (eth_rxdv && state == ST_IP_HEAD && cnt[0]),
        .add_hw  ({hw_hi, eth_rxd}),
        .fold_en (eth_rxdv && state == ST_UDP_HEAD && cnt < 11'd2),
        .sum     (csum_sum)
    );
`endif

    always_ff @(posedge eth_rxc or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= '0;
            end else if (eth_rxdv) begin
                cnt <= cnt + 11'd1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        err_nxt     = 1'b0;
        done_nxt    = 1'b0;
        strobe_nxt  = 1'b0;
        hdr_take    = 1'b0;
        uni_now     = ((cnt == 11'd0) ? 1'b1 : mac_uni_ok) && (eth_rxd == byte_of48(BOARD_MAC_ADDR, cnt[2:0]));
        bc_now      = ((cnt == 11'd0) ? 1'b1 : mac_bc_ok) && (eth_rxd == byte_of48(BROADCAST_MAC, cnt[2:0]));
        udp_len_now = {udp_len[15:8], eth_rxd};
        last_byte   = ({5'd0, cnt} + 16'd1) == rx_byte_num;
        word_nxt    = (cnt[1:0] == 2'd0) ? {eth_rxd, 24'd0}
                                         : (word_sh | ({24'd0, eth_rxd} << (8 * (3 - cnt[1:0]))));

        // A dropped rxdv after the headers were accepted is an aborted packet; earlier it is just noise.
        if (!eth_rxdv) begin
            if (state == ST_UDP_HEAD || state == ST_RX_DATA) err_nxt = 1'b1;
            if (state != ST_IDLE) next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (eth_rxd == PREAMBLE_BYTE) next_state = ST_PREAMBLE;
                end
                ST_PREAMBLE: begin
                    // The first 0x55 was consumed in IDLE: six more, then the SFD.
                    if (cnt < 11'(PREAMBLE_LEN - 1)) begin
                        if (eth_rxd != PREAMBLE_BYTE) next_state = ST_DISCARD;
                    end else begin
                        next_state = (eth_rxd == SFD_BYTE) ? ST_ETH_HEAD : ST_DISCARD;
                    end
                end
                ST_ETH_HEAD: begin
                    if (cnt < 11'd6) begin
                        if (!uni_now && !bc_now) next_state = ST_DISCARD;
                    end else if (cnt == 11'd12) begin
                        if (eth_rxd != ETH_TYPE_IPV4[15:8]) next_state = ST_DISCARD;
                    end else if (cnt == 11'(ETH_HEAD_LEN - 1)) begin
                        next_state = (eth_rxd == ETH_TYPE_IPV4[7:0]) ? ST_IP_HEAD : ST_DISCARD;
                    end
                end
                ST_IP_HEAD: begin
                    case (cnt)
                        11'd0:  if (eth_rxd != {IP_VERSION, IP_HEAD_LEN}) next_state = ST_DISCARD;
                        11'd9:  if (eth_rxd != PROTOCOL) next_state = ST_DISCARD;
                        11'd16, 11'd17, 11'd18:
                                if (eth_rxd != ip_byte(cnt[1:0])) next_state = ST_DISCARD;
                        11'(IP_HEAD_BYTES - 1):
                                next_state = (eth_rxd == ip_byte(cnt[1:0])) ? ST_UDP_HEAD : ST_DISCARD;
                        default: ;
                    endcase
                end
                ST_UDP_HEAD: begin
`ifdef UDP_RECV_IP_CHECKSUM_EN
                    if (cnt == 11'd2 && csum_sum != 16'hFFFF) begin
                        next_state = ST_DISCARD;
                        err_nxt    = 1'b1;
                    end
`endif
                    if (cnt == 11'd5 && udp_len_now < 16'(UDP_HEAD_LEN)) begin
                        next_state = ST_DISCARD;
                        err_nxt    = 1'b1;
                    end else if (cnt == 11'(UDP_HEAD_LEN - 1)) begin
                        hdr_take = 1'b1;
                        if (udp_len == 16'(UDP_HEAD_LEN)) begin
                            done_nxt   = 1'b1;
                            next_state = ST_DISCARD;
                        end else begin
                            next_state = ST_RX_DATA;
                        end
                    end
                end
                ST_RX_DATA: begin
                    strobe_nxt = (cnt[1:0] == 2'd3) || last_byte;
                    if (last_byte) begin
                        done_nxt   = 1'b1;
                        next_state = ST_DISCARD;
                    end
                end
                ST_DISCARD: ;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Header shadows and word assembly: only meaningful once the FSM qualifies them, so no reset.
    always_ff @(posedge eth_rxc) begin
        if (eth_rxdv) begin
            case (state)
                ST_ETH_HEAD: begin
                    if (cnt < 11'd6) begin
                        mac_uni_ok <= uni_now;
                        mac_bc_ok  <= bc_now;
                    end else if (cnt < 11'd12) begin
                        src_mac_sh <= {src_mac_sh[39:0], eth_rxd};
                    end
                end
                ST_IP_HEAD: begin
                    if (cnt >= 11'd12 && cnt < 11'd16) src_ip_sh <= {src_ip_sh[23:0], eth_rxd};
`ifdef UDP_RECV_IP_CHECKSUM_EN
                    if (!cnt[0]) hw_hi <= eth_rxd;
`endif
                end
                ST_UDP_HEAD: begin
                    if (cnt < 11'd2)  src_port_sh   <= {src_port_sh[7:0], eth_rxd};
                    if (cnt == 11'd4) udp_len[15:8] <= eth_rxd;
                    if (cnt == 11'd5) udp_len[7:0]  <= eth_rxd;
                end
                ST_RX_DATA: word_sh <= word_nxt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge eth_rxc or posedge rst) begin
        if (rst) begin
            rx_data      <= '0;
            rx_data_en   <= 1'b0;
            rx_byte_num  <= '0;
            rx_pkg_done  <= 1'b0;
            rx_err       <= 1'b0;
            src_mac_addr <= '0;
            src_ip_addr  <= '0;
            src_udp_port <= '0;
        end else begin
            rx_data_en  <= strobe_nxt;
            rx_pkg_done <= done_nxt;
            rx_err      <= err_nxt;
            if (strobe_nxt) rx_data <= word_nxt;
            if (hdr_take) begin
                rx_byte_num  <= udp_len - 16'(UDP_HEAD_LEN);
                src_mac_addr <= src_mac_sh;
                src_ip_addr  <= src_ip_sh;
                src_udp_port <= src_port_sh;
            end
        end
    end

endmodule

// File: doc/udp_recv.md
Name: udp_recv

Overview:
- GMII-side UDP/IPv4 frame receiver; the receive-direction counterpart of the board's UDP transmitter.
- Runs on the PHY receive clock and strips the preamble/SFD, Ethernet, IPv4 and UDP headers.
- Filters frames on destination MAC, IP address and protocol.
- Delivers the payload as big-endian 32-bit words, plus per-packet source info and length, to the user-side FIFO/logic.
- FCS is not checked here; trailing bytes up to eth_rxdv deassertion are ignored.

Parameters:
BOARD_MAC_ADDR, 48'h00_11_22_33_44_55, local MAC; broadcast FF:FF:FF:FF:FF:FF is also accepted
BOARD_IP_ADDR, {8'd192,8'd168,8'd1,8'd123}, local IPv4 address that must match the destination IP
IP_VERSION, 4'd4, required IP version nibble
IP_HEAD_LEN, 4'd5, required IHL (no options supported)
PROTOCOL, 8'd17, required IP protocol (UDP)

Ports:
eth_rxc  in  1  PHY receive clock; all logic in this domain
rst  in  1  asynchronous, active-high reset
eth_rxd  in  8  GMII receive byte
eth_rxdv  in  1  GMII receive data valid
rx_data  out  32  payload word; first byte in [31:24]
rx_data_en  out  1  1-cycle strobe, rx_data valid
rx_byte_num  out  16  payload byte count (UDP length - 8); valid from end of UDP header until the next packet
rx_pkg_done  out  1  1-cycle strobe, packet fully received and accepted
rx_err  out  1  1-cycle strobe, accepted-header packet aborted or rejected
src_mac_addr  out  48  source MAC of the last packet passing the filters
src_ip_addr  out  32  source IP of the last packet passing the filters
src_udp_port  out  16  source UDP port of the last packet passing the filters

Behaviour:
- Reset values: all outputs 0.
- Clocking: all state advances only on bytes sampled with eth_rxdv=1.
- States: IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, DISCARD.
- Byte counter: single 11-bit counter, cleared on every state change.
- IDLE -> PREAMBLE: on eth_rxdv=1 with byte 0x55.
- PREAMBLE: requires 7 x 0x55 then 0xD5 -> ETH_HEAD. Any other byte, or 0xD5 early -> DISCARD.
- ETH_HEAD (14 bytes):
  - bytes 0-5: destination MAC, must equal BOARD_MAC_ADDR or all-ones;
  - bytes 6-11: captured into a shadow source MAC;
  - bytes 12-13: must be 0x0800.
  - Mismatch -> DISCARD at the offending byte.
- IP_HEAD (20 bytes):
  - byte 0: must be {IP_VERSION,IP_HEAD_LEN};
  - byte 9: must be PROTOCOL;
  - bytes 12-15: shadow source IP;
  - bytes 16-19: must equal BOARD_IP_ADDR.
  - Other fields are ignored.
- UDP_HEAD (8 bytes):
  - bytes 0-1: shadow source port;
  - bytes 4-5: UDP length.
  - Length < 8 -> DISCARD with rx_err.
  - At byte 7: rx_byte_num <= len-8; src_* outputs updated from the shadows.
  - len == 8: pulse rx_pkg_done the next cycle, no rx_data_en, go to DISCARD.
  - Otherwise -> RX_DATA.
- RX_DATA:
  - Bytes are packed MSB first.
  - rx_data_en pulses 1 cycle after the 4th byte of each word is sampled.
  - Final partial word: unused low bytes are 0; strobed 1 cycle after the last payload byte.
  - rx_pkg_done pulses in the same cycle as the final rx_data_en; then -> DISCARD to swallow padding/FCS.
- DISCARD: waits for eth_rxdv=0, then -> IDLE.
- eth_rxdv=0 in any state other than IDLE/DISCARD:
  - in UDP_HEAD or RX_DATA, before done: rx_err pulse, no rx_pkg_done, no partial-word strobe;
  - in earlier states: silent;
  - then -> IDLE.
- Outputs held: src_* and rx_byte_num hold between packets. Packets failing the filter never alter the outputs.
- Asynchronous reset mid-packet: immediate IDLE, all outputs 0. The remainder of the in-flight frame is dropped because it never presents a valid preamble.
- Throughput: back-to-back frames with the minimum 1-cycle eth_rxdv gap must be received.

Optional Feature:
- Macro: UDP_RECV_IP_CHECKSUM_EN.
- When defined:
  - the 10 IP header halfwords are summed in a 20-bit accumulator during IP_HEAD;
  - the sum is folded twice during UDP_HEAD bytes 0-1;
  - a folded result != 16'hFFFF -> DISCARD plus rx_err pulse before any payload or src_* update.
- When undefined: the checksum bytes are ignored, with no accumulator logic.

Decomposition:
- Shared package udp_pkg:
  - state enum;
  - ETH_TYPE_IPV4 = 16'h0800, PREAMBLE_BYTE = 8'h55, SFD_BYTE = 8'hD5;
  - ETH_HEAD_LEN = 14, IP_HEAD_BYTES = 20, UDP_HEAD_LEN = 8;
  - BROADCAST_MAC.
  - The transmitter shares these constants.
- Sub-module udp_rx_csum: ones-complement halfword accumulator and fold. Present only under UDP_RECV_IP_CHECKSUM_EN; reusable for a TX checksum path.

Test Plan:
- Valid frame, 10-byte payload 01..0A to BOARD_MAC/IP -> rx_data 01020304, 05060708, 090A0000 (3 strobes); rx_byte_num=10; rx_pkg_done with the 3rd strobe; src_* match the sent values.
- Broadcast dest MAC, 4-byte payload DEADBEEF -> one strobe DEADBEEF, rx_pkg_done; followed by a frame with wrong dest IP 192.168.1.124 -> no strobes, src_* unchanged.
- Corrupted SFD (0x55 x8 then data), and EtherType 0x0806 -> no outputs; the next valid frame after a 1-cycle rxdv gap is received correctly.
- eth_rxdv dropped after 6 of 12 payload bytes -> exactly one rx_data_en (first word), rx_err pulse, no rx_pkg_done.
- UDP length field 8 -> rx_pkg_done, rx_byte_num=0, no rx_data_en. UDP length 4 -> rx_err only.
- With UDP_RECV_IP_CHECKSUM_EN: a header with a flipped checksum bit -> rx_err, no data. A correct checksum frame -> accepted. Without the macro, the flipped-checksum frame is accepted.
